// File: rtl/regfile_read_sequencer.sv
// Read-side sequencer for the register-file storage cells. Walks an inclusive, possibly
// wrapping range of registers. For each register it drives one wordline for one cycle,
// captures the shared bitline and offers the word on a valid/ready output port.
module regfile_read_sequencer #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   first_addr,
  input  logic [ADDR_W-1:0]   last_addr,
  output logic [NUM_REGS-1:0] ReadEnable,
  input  logic [WIDTH-1:0]    Bitline,
  output logic [WIDTH-1:0]    out_data,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {StIdle, StDrive, StOut, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q;
  logic [ADDR_W-1:0]   last_q;
  logic [ADDR_W-1:0]   cur_inc;
  logic [WIDTH-1:0]    out_data_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                handshake;
  logic                at_last;

  // Next sweep address, wrapping from the top register back to zero
  assign cur_inc   = (cur_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_q + ADDR_W'(1);
  assign handshake = (state_q == StOut) && out_ready;
  assign at_last   = (cur_q == last_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks a same-cycle handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StDrive;
      end
      StDrive: begin
        state_d = abort ? StIdle : StOut;
      end
      StOut: begin
        if (abort) begin
          state_d = StIdle;
        end else if (out_ready) begin
          state_d = at_last ? StDone : StDrive;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sweep bounds, current address and captured beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q      <= '0;
      last_q     <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_q  <= first_addr;
            last_q <= last_addr;
          end
        end
        StDrive: begin
          // Bitline is only meaningful while the wordline is up
          if (!abort) begin
            out_data_q <= Bitline;
            out_addr_q <= cur_q;
          end
        end
        StOut: begin
          if (!abort && handshake && !at_last) cur_q <= cur_inc;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so reset and abort clear them without delay
  always_comb begin
    ReadEnable = '0;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StIdle:  ;
      StDrive: ReadEnable = NUM_REGS'(1) << cur_q;
      StOut:   out_valid = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign out_data = out_data_q;
  assign out_addr = out_addr_q;

  // Wordlines must never short two cells onto the bitline
  a_read_enable_onehot0 : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(ReadEnable));

  // A stalled beat stays put until accepted
  a_out_stable : assert property (@(posedge clk) disable iff (!rst)
    (state_q == StOut && !out_ready && !abort) |=>
      (out_valid && $stable(out_data) && $stable(out_addr)));

endmodule

// File: tb/tb_regfile_read_sequencer.sv
// Directed bench for regfile_read_sequencer with a behavioural register array on the bitline.
module tb_regfile_read_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  first_addr;
  logic [3:0]  last_addr;
  logic [15:0] read_enable;
  logic [15:0] bitline;
  logic [15:0] out_data;
  logic [3:0]  out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [15:0] regs [16];

  int n_checks = 0;
  int n_fail   = 0;

  int          beat_a [$];
  logic [15:0] beat_d [$];
  int          beat_c [$];
  logic [15:0] re_log [$];
  int          done_cnt;
  int          done_cyc;
  int          idle_cyc;

  localparam logic [15:0] WrapRe [4] = '{16'h4000, 16'h8000, 16'h0001, 16'h0002};

  regfile_read_sequencer #(
    .NUM_REGS (16),
    .WIDTH    (16),
    .ADDR_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .ReadEnable (read_enable),
    .Bitline    (bitline),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage array model: the selected cell drives the shared bitline
  always_comb begin
    bitline = '0;
    for (int i = 0; i < 16; i++) begin
      if (read_enable[i]) bitline = bitline | regs[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one sweep from a negedge; optional stall of one beat and abort raised with start
  task automatic sweep(input logic [3:0] f, input logic [3:0] l, input int stall_beat,
                       input int stall_len, input bit abort_at_start);
    int          beat_idx  = 0;
    int          stall_cnt = 0;
    logic [3:0]  hold_a    = '0;
    logic [15:0] hold_d    = '0;
    beat_a.delete();
    beat_d.delete();
    beat_c.delete();
    re_log.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    idle_cyc   = -1;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    abort      = abort_at_start;
    out_ready  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (c == 1) begin
        // Bounds must have been latched on start
        first_addr = ~f;
        last_addr  = ~l;
      end
      check("re_onehot0", 32'($onehot0(read_enable)), 32'd1);
      if (read_enable != 0) re_log.push_back(read_enable);
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (!busy) begin
        idle_cyc = c;
        break;
      end
      if (out_valid) begin
        if (beat_idx == stall_beat && stall_cnt < stall_len) begin
          if (stall_cnt == 0) begin
            hold_a = out_addr;
            hold_d = out_data;
          end else begin
            check("stall_addr", out_addr, hold_a);
            check("stall_data", out_data, hold_d);
          end
          check("stall_re", read_enable, 16'h0000);
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
          beat_a.push_back(int'(out_addr));
          beat_d.push_back(out_data);
          beat_c.push_back(c);
          beat_idx++;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    if (idle_cyc < 0) check("sweep_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_beats(input string tag, input int f, input int n);
    check({tag, "_count"}, beat_a.size(), n);
    for (int j = 0; j < n && j < beat_a.size(); j++) begin
      check({tag, "_addr"}, beat_a[j], (f + j) % 16);
      check({tag, "_data"}, beat_d[j], regs[(f + j) % 16]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    out_ready  = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 16'h1111 * 16'(i);

    // 1: reset with random inputs
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_re", read_enable, 16'h0000);
      check("rst_data", out_data, 16'h0000);
      check("rst_addr", out_addr, 4'h0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      start      = 1'($urandom);
      abort      = 1'($urandom);
      first_addr = 4'($urandom);
      last_addr  = 4'($urandom);
      out_ready  = 1'($urandom);
    end
    @(negedge clk);
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_re", read_enable, 16'h0000);

    // 2: basic sweep 0..3, two cycles per beat, done nine cycles after start
    sweep(4'd0, 4'd3, -1, 0, 1'b0);
    check_beats("t2", 0, 4);
    for (int j = 0; j < 4 && j < beat_c.size(); j++) check("t2_cycle", beat_c[j], 2 * j + 2);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_done_cyc", done_cyc, 9);
    check("t2_idle_cyc", idle_cyc, 10);
    check("t2_retain_addr", out_addr, 4'd3);
    check("t2_retain_data", out_data, 16'h3333);

    // 3: wrapping sweep 14..1
    for (int i = 0; i < 16; i++) regs[i] = ~16'(i);
    sweep(4'd14, 4'd1, -1, 0, 1'b0);
    check_beats("t3", 14, 4);
    check("t3_re_count", re_log.size(), 4);
    for (int j = 0; j < 4 && j < re_log.size(); j++) check("t3_re", re_log[j], WrapRe[j]);
    check("t3_done_cnt", done_cnt, 1);

    // 4: third beat stalled five cycles
    sweep(4'd4, 4'd7, 2, 5, 1'b0);
    check_beats("t4", 4, 4);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_done_cyc", done_cyc, 14);

    // Single-register sweep; abort in IDLE alongside start is ignored
    sweep(4'd7, 4'd7, -1, 0, 1'b1);
    check_beats("t1reg", 7, 1);
    check("t1reg_done_cyc", done_cyc, 3);
    check("t1reg_idle_cyc", idle_cyc, 4);

    // 5: start while busy ignored; abort during OUT of the second beat
    first_addr = 4'd2;
    last_addr  = 4'd5;
    start      = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_re0", read_enable, 16'h0004);
    first_addr = 4'd9;
    @(negedge clk);
    check("t5_b0_valid", out_valid, 1'b1);
    check("t5_b0_addr", out_addr, 4'd2);
    start = 1'b0;
    @(negedge clk);
    check("t5_re1", read_enable, 16'h0008);
    @(negedge clk);
    check("t5_b1_valid", out_valid, 1'b1);
    check("t5_b1_addr", out_addr, 4'd3);
    check("t5_b1_data", out_data, 16'hFFFC);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_ab_busy", busy, 1'b0);
    check("t5_ab_valid", out_valid, 1'b0);
    check("t5_ab_re", read_enable, 16'h0000);
    check("t5_ab_done", done, 1'b0);
    check("t5_ab_addr", out_addr, 4'd3);
    check("t5_ab_data", out_data, 16'hFFFC);
    @(negedge clk);
    check("t5_ab_done2", done, 1'b0);
    check("t5_ab_busy2", busy, 1'b0);

    // 6: asynchronous reset between edges while a wordline is up
    first_addr = 4'd0;
    last_addr  = 4'd3;
    start      = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    check("t6_re_pre", read_enable, 16'h0001);
    #1 rst = 1'b0;
    #1;
    check("t6_re", read_enable, 16'h0000);
    check("t6_valid", out_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_data", out_data, 16'h0000);
    check("t6_addr", out_addr, 4'h0);
    check("t6_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sweep(4'd0, 4'd3, -1, 0, 1'b0);
    check_beats("t6", 0, 4);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_done_cyc", done_cyc, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
